// File: rtl/pipeline_control.sv
// pipeline_control: run/step/halt sequencing plus load-use stall and branch flush control for a 5-stage pipeline.
module pipeline_control #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_cmd,
    input  logic                      step_cmd,
    input  logic                      stop_cmd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_halt,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      mem_branch_taken,
    output logic                      pipe_en,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      exmem_flush,
    output logic                      halted,
    output logic [CNT_WIDTH-1:0]      cycle_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;

    state_t              r_state, w_next;
    logic [DW-1:0]       r_drain;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic                w_active, w_drain, w_hazard, w_branch, w_stall, w_halt_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_drain       <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_next;
            r_drain       <= (r_state == DRAIN) ? r_drain + DW'(1) : '0;
            r_cycle_count <= pipe_en ? r_cycle_count + CNT_WIDTH'(1) : r_cycle_count;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = run_cmd ? RUN : (step_cmd ? STEP : IDLE);
            RUN:     w_next = w_halt_acc ? DRAIN : (stop_cmd ? IDLE : RUN);
            STEP:    w_next = w_halt_acc ? DRAIN : IDLE;
            DRAIN:   w_next = (r_drain == DRAIN_LAST) ? HALTED : DRAIN;
            HALTED:  w_next = HALTED;
            default: w_next = IDLE;
        endcase
    end

    // Reset also masks every output so nothing is enabled while it is held.
    always_comb begin
        w_active    = (r_state == RUN || r_state == STEP) && !reset;
        w_drain     = (r_state == DRAIN) && !reset;
        w_hazard    = ex_mem_read && (ex_rt != '0) && (ex_rt == id_rs || ex_rt == id_rt);
        w_branch    = (w_active || w_drain) && mem_branch_taken;
        w_stall     = (w_active || w_drain) && w_hazard && !mem_branch_taken;
        w_halt_acc  = w_active && id_halt && !w_stall && !w_branch;
        pipe_en     = w_active || w_drain;
        pc_write    = w_active && !w_stall;
        ifid_write  = w_drain || (w_active && !w_stall);
        ifid_flush  = w_drain || w_branch;
        idex_flush  = w_branch || w_stall;
        exmem_flush = w_branch;
        halted      = (r_state == HALTED) && !reset;
    end

    assign cycle_count = r_cycle_count;
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed vectors with hand-computed expectations for pipeline_control.
module tb_pipeline_control;
    logic       clk = 0;
    logic       reset, run_cmd, step_cmd, stop_cmd, id_halt, ex_mem_read, mem_branch_taken;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pipe_en, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted;
    logic [31:0] cycle_count;
    int n_chk = 0;
    int n_err = 0;

    pipeline_control dut (
        .clk(clk), .reset(reset), .run_cmd(run_cmd), .step_cmd(step_cmd), .stop_cmd(stop_cmd),
        .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .pipe_en(pipe_en), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Output vector order: pipe_en, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted.
    wire [6:0] outs = {pipe_en, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, halted};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_haz(input logic rd, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt, input logic br);
        ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt; mem_branch_taken = br;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0; tick();
    endtask

    initial begin
        reset = 1; run_cmd = 0; step_cmd = 0; stop_cmd = 0; id_halt = 0;
        set_haz(0, 0, 0, 0, 0);
        tick();
        settle(); chk("rst_outs", 32'(outs), 32'b0000000);
        chk("rst_cnt", cycle_count, 0);
        reset = 0; settle();
        chk("post_rst_outs", 32'(outs), 32'b0000000);
        // run for 10 enabled cycles, then stop
        run_cmd = 1; settle();
        chk("idle_run_req", 32'(pipe_en), 0);
        tick(); run_cmd = 0; settle();
        chk("run_outs", 32'(outs), 32'b1110000);
        for (int i = 0; i < 9; i++) tick();
        chk("run_cnt9", cycle_count, 9);
        stop_cmd = 1; tick(); stop_cmd = 0; settle();
        chk("stop_pe", 32'(pipe_en), 0);
        chk("stop_cnt", cycle_count, 10);
        tick(); tick();
        chk("hold_cnt", cycle_count, 10);
        // three single steps with gaps
        do_reset();
        chk("rst2_cnt", cycle_count, 0);
        for (int s = 0; s < 3; s++) begin
            step_cmd = 1; tick(); step_cmd = 0; settle();
            chk("step_pe", 32'(outs), 32'b1110000);
            tick();
            chk("step_back_idle", 32'(pipe_en), 0);
            tick();
        end
        chk("step_cnt", cycle_count, 3);
        // hazards in RUN
        run_cmd = 1; step_cmd = 1; tick(); run_cmd = 0; step_cmd = 0;
        set_haz(1, 5, 0, 5, 0); settle();
        chk("load_use", 32'(outs), 32'b1000100);
        set_haz(1, 5, 5, 9, 0); settle();
        chk("load_use_rs", 32'(outs), 32'b1000100);
        set_haz(1, 0, 0, 0, 0); settle();
        chk("r0_no_stall", 32'(outs), 32'b1110000);
        set_haz(0, 5, 0, 5, 0); settle();
        chk("no_load", 32'(outs), 32'b1110000);
        set_haz(1, 5, 0, 5, 1); id_halt = 1; settle();
        chk("br_over_stall", 32'(outs), 32'b1111110);
        tick();
        set_haz(1, 5, 0, 5, 0); settle();
        chk("halt_ignored_br", 32'(outs), 32'b1000100);
        tick();
        set_haz(0, 0, 0, 0, 0); settle();
        chk("halt_ignored_stall", 32'(outs), 32'b1110000);
        chk("cnt_before_halt", cycle_count, 5);
        tick(); id_halt = 0;
        for (int d = 0; d < 4; d++) begin
            mem_branch_taken = (d == 1); settle();
            chk("drain_outs", 32'(outs), (d == 1) ? 32'b1011110 : 32'b1011000);
            tick();
        end
        mem_branch_taken = 0;
        chk("halted_outs", 32'(outs), 32'b0000001);
        chk("halted_cnt", cycle_count, 10);
        run_cmd = 1; step_cmd = 1; tick(); run_cmd = 0; step_cmd = 0; tick();
        chk("halted_sticky", 32'(outs), 32'b0000001);
        chk("halted_cnt_hold", cycle_count, 10);
        // reset in the middle of DRAIN
        do_reset();
        run_cmd = 1; tick(); run_cmd = 0; id_halt = 1; tick(); id_halt = 0; tick();
        chk("drain2_outs", 32'(outs), 32'b1011000);
        chk("drain2_cnt", cycle_count, 2);
        reset = 1; settle();
        chk("in_rst_outs", 32'(outs), 32'b0000000);
        tick(); reset = 0; settle();
        chk("after_rst_outs", 32'(outs), 32'b0000000);
        chk("after_rst_cnt", cycle_count, 0);
        run_cmd = 1; tick(); run_cmd = 0; settle();
        chk("rerun_outs", 32'(outs), 32'b1110000);
        tick();
        chk("rerun_cnt", cycle_count, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
